systolic_mm_engine: RTL
=======================

# systolic_mm_engine

- Parametrised N×N output-stationary systolic matrix multiplier computing C = A·B, or C += A·B in accumulate mode.
- Operand skewing is built in: the host streams one column of A and one row of B per beat, unskewed.
- Results leave row by row over a valid/ready port.
- Sits between the operand buffers and the result writeback in the matrix datapath, and replaces hand-skewed fixed 4×4 arrays.

## Interface
- DATA_WIDTH, 32, operand width
- N, 4, array dimension (N ≥ 2)
- SIGNED, 0, 1 = two's-complement multiply/accumulate, 0 = unsigned
- ACC_WIDTH, 2*DATA_WIDTH+$clog2(N), accumulator / result element width

- clk_i  in  1  clock, all logic on rising edge
- rst_i  in  1  synchronous, active-high reset
- start_i  in  1  begin a job; honoured in IDLE only
- accum_i  in  1  sampled with start_i; 1 = keep accumulators (C += A·B)
- in_valid_i  in  1  operand beat valid
- in_ready_o  out  1  high in LOAD
- a_col_i  in  N*DATA_WIDTH  beat k: element i = A[i][k], bits [i*DATA_WIDTH +: DATA_WIDTH]
- b_row_i  in  N*DATA_WIDTH  beat k: element j = B[k][j]
- out_valid_o  out  1  result row valid
- out_ready_i  in  1  consumer accepts row
- out_row_o  out  $clog2(N)  index r of presented row
- c_row_o  out  N*ACC_WIDTH  element j = C[r][j]
- busy_o  out  1  state ≠ IDLE
- done_o  out  1  one-cycle pulse after last row accepted

## Operation
- FSM IDLE → LOAD → DRAIN → OUT → IDLE.
- **IDLE:**
  - start_i=1 → LOAD.
  - If accum_i=0, clear all accumulators.
  - Clear the beat counter.
  - Operand beats are ignored in IDLE.
- **LOAD:**
  - Beat accepted when in_valid_i && in_ready_o.
  - Lane i of A is delayed i cycles, lane j of B is delayed j cycles (skew registers).
  - A values move right one PE per cycle, B values move down one PE per cycle.
  - Cycles without a valid beat inject zeros on all lanes. A zero pairs only with zero, so it does not change the result.
  - After the N-th accepted beat → DRAIN.
- **DRAIN:**
  - Fixed 2N-1 cycles, with zeros injected.
  - Then → OUT, with row index r=0.
- **PE(i,j):**
  - Each cycle: acc += a_in*b_in, then register a to the right neighbour and b to the lower neighbour.
  - Product is sign- or zero-extended per SIGNED to ACC_WIDTH.
  - Accumulation wraps modulo 2^ACC_WIDTH; there is no saturation and no overflow flag.
- **OUT:**
  - out_valid_o=1, c_row_o = accumulators of row r.
  - On out_ready_i=1, r increments.
  - After row N-1 is accepted → IDLE and pulse done_o.
- **Ignored inputs:**
  - start_i outside IDLE.
  - in_valid_i outside LOAD.
- **rst_i, any state:**
  - → IDLE.
  - Skew, pipeline and accumulator registers cleared to 0.
  - Counters cleared.
  - A job in flight is discarded.

## Timing
- **Reset values:** in_ready_o=0, out_valid_o=0, out_row_o=0, c_row_o=0, busy_o=0, done_o=0.
- **start_i edge:** in_ready_o rises in the following cycle.
- **Minimum job latency:**
  - Start accepted at edge S, N back-to-back beats, last beat at edge L = S+N.
  - Final MAC in PE(N-1,N-1) at edge L+2N-1.
  - out_valid_o is high from the cycle after edge L+2N-1.
- **Output stall:** while out_valid_o && !out_ready_i, out_row_o and c_row_o are held stable.
- **Row throughput:** one row per cycle when out_ready_i is held high.
- **Job throughput:**
  - done_o is high in the cycle after the edge that accepts row N-1; busy_o is low in that same cycle.
  - start_i is accepted in that cycle, giving back-to-back jobs.
- Bubbles in LOAD only extend LOAD. The DRAIN length counts from the last beat.

## Structure
- **Package systolic_pkg:**
  - FSM state enum (IDLE, LOAD, DRAIN, OUT).
  - Function acc_width(DATA_WIDTH, N).
  - Sign/zero-extend helper used by the PE.
- **Sub-module systolic_pe:**
  - One MAC cell: a/b pass-through registers plus accumulator, with a clear input and an enable input.
  - Instantiated N×N by generate.
- Skew delay lines and the FSM live in the top module.

## Test plan
- **Basic 4×4 (N=4, DATA_WIDTH=32):**
  - A rows 1..16 row-major, B[k][j]=j+1, accum_i=0, out_ready_i=1.
  - Rows out: (10,20,30,40), (26,52,78,104), (42,84,126,168), (58,116,174,232).
  - out_valid_o first high in the cycle after edge L+7.
- **Accumulate:** rerun the same operands with accum_i=1 → row 0 = (20,40,60,80), row 3 = (116,232,348,464).
- **Input bubbles and ignored start:**
  - in_valid_i=0 for 3 cycles between beats 1 and 2 → identical results.
  - out_valid_o starts 2N-1 cycles after the last beat.
  - A start_i pulse during LOAD has no effect.
- **Output backpressure:**
  - out_ready_i=0 for 5 cycles while row 1 is presented → out_row_o=1 and c_row_o=(26,52,78,104) held stable.
  - done_o pulses once, after row 3 is accepted.
- **Wrap (DATA_WIDTH=8, N=2, SIGNED=0, ACC_WIDTH=17), all operands 255:**
  - First job gives 130050 in every element.
  - Second job with accum_i=1 gives 129028 (260100 mod 131072).
  - SIGNED=1 variant, all operands −1: 2 after the first job, 4 after the second.
- **Reset mid-DRAIN:**
  - rst_i for 1 cycle → next cycle busy_o=0, out_valid_o=0.
  - A following accum_i=1 job with the basic-test operands yields the basic-test results, proving the accumulators were cleared.

Source files
------------

// File: rtl/systolic_mm_engine_pkg.sv
// ============================================================================
// Module  : systolic_pkg
// Brief   : Shared types and helpers for the systolic matrix-multiply engine.
// Revision: 1.0
// ============================================================================
`default_nettype none

package systolic_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        DRAIN = 2'd2,
        OUT   = 2'd3
    } state_t;

    localparam int C_EXT_WIDTH = 256;

    function automatic int acc_width(input int data_width, input int n);
        return 2 * data_width + $clog2(n);
    endfunction

    // Widens a width-bit value to C_EXT_WIDTH bits, sign- or zero-filling above it.
    function automatic logic [C_EXT_WIDTH-1:0] extend(
        input logic [C_EXT_WIDTH-1:0] value,
        input int                     width,
        input bit                     is_signed
    );
        logic [C_EXT_WIDTH-1:0] mask;
        logic [C_EXT_WIDTH-1:0] top;
        logic                   sign;
        mask = ~({C_EXT_WIDTH{1'b1}} << width);
        top  = value >> (width - 1);
        sign = is_signed & top[0];
        return (value & mask) | (~mask & {C_EXT_WIDTH{sign}});
    endfunction

endpackage

`default_nettype wire

// File: rtl/systolic_mm_engine_pe.sv
// ============================================================================
// Module  : systolic_pe
// Brief   : One output-stationary MAC cell with a/b pass-through registers.
// Revision: 1.0
// ============================================================================
`default_nettype none

module systolic_pe
    import systolic_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ACC_WIDTH  = 66,
    parameter bit SIGNED     = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_clr,
    input  logic                  i_en,
    input  logic [DATA_WIDTH-1:0] i_a,
    input  logic [DATA_WIDTH-1:0] i_b,
    output logic [DATA_WIDTH-1:0] o_a,
    output logic [DATA_WIDTH-1:0] o_b,
    output logic [ACC_WIDTH-1:0]  o_acc
);

    localparam int C_PROD_WIDTH = 2 * DATA_WIDTH;

    logic [C_PROD_WIDTH-1:0] w_prod;
    logic [ACC_WIDTH-1:0]    w_prod_ext;
    logic [DATA_WIDTH-1:0]   r_a;
    logic [DATA_WIDTH-1:0]   r_b;
    logic [ACC_WIDTH-1:0]    r_acc;

    generate
        if (SIGNED) begin : g_signed
            assign w_prod = $signed({{DATA_WIDTH{i_a[DATA_WIDTH-1]}}, i_a})
                          * $signed({{DATA_WIDTH{i_b[DATA_WIDTH-1]}}, i_b});
        end else begin : g_unsigned
            assign w_prod = {{DATA_WIDTH{1'b0}}, i_a} * {{DATA_WIDTH{1'b0}}, i_b};
        end
    endgenerate

    assign w_prod_ext = ACC_WIDTH'(extend(C_EXT_WIDTH'(w_prod), C_PROD_WIDTH, SIGNED));

    // Accumulation wraps at ACC_WIDTH bits by design.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc <= '0;
            r_a   <= '0;
            r_b   <= '0;
        end else begin
            if (i_clr) begin
                r_acc <= '0;
            end else if (i_en) begin
                r_acc <= r_acc + w_prod_ext;
            end
            if (i_en) begin
                r_a <= i_a;
                r_b <= i_b;
            end
        end
    end

    assign o_a   = r_a;
    assign o_b   = r_b;
    assign o_acc = r_acc;

endmodule

`default_nettype wire

// File: rtl/systolic_mm_engine.sv
// ============================================================================
// Module  : systolic_mm_engine
// Brief   : NxN output-stationary systolic C = A*B / C += A*B with built-in skew.
// Revision: 1.0
// ============================================================================
`default_nettype none

module systolic_mm_engine
    import systolic_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int N          = 4,
    parameter bit SIGNED     = 1'b0,
    parameter int ACC_WIDTH  = acc_width(DATA_WIDTH, N)
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    start_i,
    input  logic                    accum_i,
    input  logic                    in_valid_i,
    output logic                    in_ready_o,
    input  logic [N*DATA_WIDTH-1:0] a_col_i,
    input  logic [N*DATA_WIDTH-1:0] b_row_i,
    output logic                    out_valid_o,
    input  logic                    out_ready_i,
    output logic [$clog2(N)-1:0]    out_row_o,
    output logic [N*ACC_WIDTH-1:0]  c_row_o,
    output logic                    busy_o,
    output logic                    done_o
);

    localparam int C_BEAT_W  = $clog2(N);
    localparam int C_DRAIN_W = $clog2(2 * N - 1);
    localparam int C_ROW_W   = $clog2(N);
    localparam logic [C_BEAT_W-1:0]  C_BEAT_LAST  = C_BEAT_W'(N - 1);
    localparam logic [C_DRAIN_W-1:0] C_DRAIN_LAST = C_DRAIN_W'(2 * N - 2);
    localparam logic [C_ROW_W-1:0]   C_ROW_LAST   = C_ROW_W'(N - 1);

    state_t                 r_state;
    logic [C_BEAT_W-1:0]    r_beat_cnt;
    logic [C_DRAIN_W-1:0]   r_drain_cnt;
    logic [C_ROW_W-1:0]     r_row;
    logic                   r_done;

    logic                   w_beat;
    logic                   w_clr;
    logic                   w_pe_en;
    logic                   w_unused;

    logic [DATA_WIDTH-1:0]  w_a_h [N][N+1];
    logic [DATA_WIDTH-1:0]  w_b_v [N+1][N];
    logic [ACC_WIDTH-1:0]   w_acc [N][N];

    assign w_beat  = (r_state == LOAD) && in_valid_i;
    assign w_clr   = (r_state == IDLE) && start_i && !accum_i;
    assign w_pe_en = (r_state == LOAD) || (r_state == DRAIN);

    // Lane i gets i+1 register stages so PE(i,j) sees A[i][k] and B[k][j] on the same edge.
    generate
        for (genvar i = 0; i < N; i++) begin : g_skew
            logic [DATA_WIDTH-1:0] r_a_dly [0:i];
            logic [DATA_WIDTH-1:0] r_b_dly [0:i];

            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    for (int m = 0; m <= i; m++) begin
                        r_a_dly[m] <= '0;
                        r_b_dly[m] <= '0;
                    end
                end else begin
                    r_a_dly[0] <= w_beat ? a_col_i[i*DATA_WIDTH +: DATA_WIDTH] : '0;
                    r_b_dly[0] <= w_beat ? b_row_i[i*DATA_WIDTH +: DATA_WIDTH] : '0;
                    for (int m = 1; m <= i; m++) begin
                        r_a_dly[m] <= r_a_dly[m-1];
                        r_b_dly[m] <= r_b_dly[m-1];
                    end
                end
            end

            assign w_a_h[i][0] = r_a_dly[i];
            assign w_b_v[0][i] = r_b_dly[i];
        end
    endgenerate

    generate
        for (genvar i = 0; i < N; i++) begin : g_row
            for (genvar j = 0; j < N; j++) begin : g_col
                systolic_pe #(
                    .DATA_WIDTH (DATA_WIDTH),
                    .ACC_WIDTH  (ACC_WIDTH),
                    .SIGNED     (SIGNED)
                ) u_pe (
                    .clk   (clk_i),
                    .rst   (rst_i),
                    .i_clr (w_clr),
                    .i_en  (w_pe_en),
                    .i_a   (w_a_h[i][j]),
                    .i_b   (w_b_v[i][j]),
                    .o_a   (w_a_h[i][j+1]),
                    .o_b   (w_b_v[i+1][j]),
                    .o_acc (w_acc[i][j])
                );
            end
        end
    endgenerate

    // The right/bottom edge pass-through outputs have no consumer.
    always_comb begin
        w_unused = 1'b0;
        for (int i = 0; i < N; i++) begin
            w_unused = w_unused ^ (^w_a_h[i][N]) ^ (^w_b_v[N][i]);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= IDLE;
            r_beat_cnt  <= '0;
            r_drain_cnt <= '0;
            r_row       <= '0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_beat_cnt  <= '0;
                    r_drain_cnt <= '0;
                    r_row       <= '0;
                    if (start_i) begin
                        r_state <= LOAD;
                    end
                end
                LOAD: begin
                    if (in_valid_i) begin
                        if (r_beat_cnt == C_BEAT_LAST) begin
                            r_state     <= DRAIN;
                            r_drain_cnt <= '0;
                        end
                        r_beat_cnt <= r_beat_cnt + C_BEAT_W'(1);
                    end
                end
                DRAIN: begin
                    if (r_drain_cnt == C_DRAIN_LAST) begin
                        r_state <= OUT;
                        r_row   <= '0;
                    end else begin
                        r_drain_cnt <= r_drain_cnt + C_DRAIN_W'(1);
                    end
                end
                OUT: begin
                    if (out_ready_i) begin
                        if (r_row == C_ROW_LAST) begin
                            r_state <= IDLE;
                            r_row   <= '0;
                            r_done  <= 1'b1;
                        end else begin
                            r_row <= r_row + C_ROW_W'(1);
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Accumulators are frozen outside LOAD/DRAIN, so the row mux is stable during a stall.
    always_comb begin
        c_row_o = '0;
        for (int j = 0; j < N; j++) begin
            c_row_o[j*ACC_WIDTH +: ACC_WIDTH] = w_acc[r_row][j];
        end
    end

    assign in_ready_o  = (r_state == LOAD);
    assign out_valid_o = (r_state == OUT);
    assign busy_o      = (r_state != IDLE);
    assign done_o      = r_done;
    assign out_row_o   = r_row;

endmodule

`default_nettype wire
